l2_sumsq_vec: RTL and testbench
===============================

Name: l2_sumsq_vec

Overview:
Parametrised successor to the single-stream square-accumulate datapath. It accepts a stream of signed samples and computes the sum of squares over fixed-length vectors of VEC_LEN elements. At the end of each vector it emits one result with a valid strobe and an overflow flag. It has an optional squarer pipeline stage, optional saturation, and a synchronous vector abort. It feeds the downstream sqrt/normalise stage of the L2-norm datapath.

Parameters:
IN_W, 8, width of signed input sample a
ACC_W, 20, width of unsigned accumulator and result f
VEC_LEN, 4, elements per vector (>=1); one result per VEC_LEN accepted samples
PIPE, 1, 1 = registered squarer stage, 0 = combinational squarer
SATURATE, 1, 1 = clamp f to 2^ACC_W-1 on overflow, 0 = f wraps modulo 2^ACC_W

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
a  input  IN_W  signed two's-complement sample
valid_in  input  1  a is accepted on any rising edge where valid_in=1 and clr=0
clr  input  1  synchronous abort; discards the partial vector
f  output  ACC_W  sum of squares of the last completed vector
valid_out  output  1  one-cycle strobe; f and overflow are new this cycle
overflow  output  1  the last completed vector exceeded ACC_W range

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - On reset: f=0, valid_out=0, overflow=0, acc=0, element count=0, pipeline valid=0, sticky overflow=0.
- Squarer:
  - prod = a*a is computed signed and carried as unsigned, 2*IN_W bits wide.
  - (-2^(IN_W-1))^2 = 2^(2*IN_W-2) must be exact; for IN_W=8, -128 gives 16384.
- Pipeline:
  - PIPE=1: prod and its valid are registered on the accept edge E, and accumulation happens on edge E+1.
  - PIPE=0: accumulation happens on edge E.
  - valid_out is high for exactly one cycle after edge E+PIPE of the VEC_LEN-th accepted element.
- Element counter:
  - Counts 0..VEC_LEN-1 on accumulate events, which are the pipelined valids.
  - On the last element it wraps to 0; acc is reloaded with 0 on the same edge as the result is produced.
  - No bubble cycle is needed between vectors; back-to-back valid_in is supported at full rate.
  - valid_in=0 cycles hold all state.
- Arithmetic:
  - sum = acc + prod is computed at ACC_W+1 bits (prod zero-extended or truncated to ACC_W with its upper bits OR-ed into the overflow detect).
  - The sticky ovf bit sets if the carry or the dropped upper bits are nonzero.
  - Once ovf is set, the acc value is don't-care; the result is decided by SATURATE.
- Result on the last element:
  - f <= (ovf_final && SATURATE) ? all ones : sum[ACC_W-1:0]
  - overflow <= ovf_final
  - valid_out <= 1
  - Sticky ovf clears for the next vector.
- Hold behaviour: f and overflow hold their values between strobes; valid_out=0 otherwise.
- clr:
  - Zeroes acc, the counter, sticky ovf and the in-flight pipeline valid on the next edge.
  - Samples presented with clr=1 are dropped; clr wins over valid_in.
  - f and overflow are unaffected.
  - If the pipelined last element is in flight on the clr edge, it is dropped and no valid_out is produced.
- Reset mid-vector: the partial vector is discarded and the first accepted sample after deassertion is element 0.
- VEC_LEN=1: every accepted sample produces a result after PIPE+1 edges.

Decomposition:
- Package l2_pkg holds:
  - default constants IN_W_D=8, ACC_W_D=20, VEC_LEN_D=4
  - localparam helper CNT_W = $clog2(VEC_LEN) with a minimum of 1
  - PROD_W = 2*IN_W
- One sub-module, l2_square_stage (parameters IN_W, PIPE):
  - Inputs: clk, reset, a, valid_in, kill (=clr).
  - Outputs: prod, prod_valid.
  - It owns the optional register stage.
- Counter, accumulator, overflow and output logic live in the top level.

Test Plan:
1. Defaults; a=1,2,3,4 on consecutive valid_in cycles -> f=30, overflow=0; valid_out high for one cycle, 2 edges after the 4th sample's accept edge.
2. Defaults; a=-128,-128,-128,-128, then immediately a=-1,0,1,2 -> first strobe f=65536, second strobe f=6, strobes 4 cycles apart, no lost element.
3. ACC_W=16, SATURATE=1; a=-128 x4 -> f=65535, overflow=1. Repeat with SATURATE=0 -> f=0, overflow=1. A following vector of 1,1,1,1 -> f=4, overflow=0, which shows the sticky bit clears.
4. Defaults; a=5,5 then clr=1 for one cycle, then a=1,1,1,1 -> the only strobe has f=4. A sample with valid_in=1 and clr=1 simultaneously is not counted.
5. Defaults; a=3,3, then assert reset asynchronously mid-cycle -> f=0, valid_out=0 and overflow=0 immediately. After release, a=2,2,2,2 -> f=16.
6. PIPE=0, VEC_LEN=1; a=7, then idle, then a=-3 -> strobes 1 edge after each accept with f=49 then f=9; valid_in gaps keep valid_out low.

Source files
------------

// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared constants and width helpers for the L2 sum-of-squares datapath
//
// Purpose: default parameter values and width helpers shared by l2_square_stage
// and l2_sumsq_vec.
package l2_pkg;

  localparam int IN_W_D    = 8;
  localparam int ACC_W_D   = 20;
  localparam int VEC_LEN_D = 4;

  // Element counter width; a one-element vector still needs a 1-bit counter.
  function automatic int cnt_width(input int vec_len);
    return (vec_len <= 2) ? 1 : $clog2(vec_len);
  endfunction

  // Width of an exact square of an in_w-bit signed sample.
  function automatic int prod_width(input int in_w);
    return 2 * in_w;
  endfunction

  localparam int CNT_W_D  = cnt_width(VEC_LEN_D);
  localparam int PROD_W_D = prod_width(IN_W_D);

endpackage

// File: rtl/l2_square_stage.sv
// rtl/l2_square_stage.sv - signed squarer with optional output register
//
// Purpose: squares a signed sample exactly and optionally registers the result.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   a          signed sample, IN_W bits
//   valid_in   sample strobe
//   kill       synchronous abort; drops the sample presented this cycle and
//              clears the in-flight registered valid
//   prod       a*a as unsigned, 2*IN_W bits
//   prod_valid prod is an accepted square (registered when PIPE=1)
module l2_square_stage
  import l2_pkg::*;
#(
  parameter int IN_W = IN_W_D,
  parameter int PIPE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [IN_W-1:0]      a,
  input  logic                        valid_in,
  input  logic                        kill,
  output logic [prod_width(IN_W)-1:0] prod,
  output logic                        prod_valid
);

  localparam int PROD_W = prod_width(IN_W);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] sq_s;
  logic [PROD_W-1:0]        sq;
  logic                     accept;

  // Sign-extend before multiplying so (-2^(IN_W-1))^2 is exact.
  assign a_ext  = {{IN_W{a[IN_W-1]}}, a};
  assign sq_s   = a_ext * a_ext;
  assign sq     = sq_s;
  assign accept = valid_in && !kill;

  if (PIPE != 0) begin : g_pipe
    logic [PROD_W-1:0] prod_d, prod_q;
    logic              valid_d, valid_q;

    always_comb begin
      prod_d  = prod_q;
      valid_d = accept;
      if (accept) begin
        prod_d = sq;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prod_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        prod_q  <= prod_d;
        valid_q <= valid_d;
      end
    end

    assign prod       = prod_q;
    assign prod_valid = valid_q;
  end else begin : g_comb
    assign prod       = sq;
    assign prod_valid = accept;
  end

endmodule

// File: rtl/l2_sumsq_vec.sv
// rtl/l2_sumsq_vec.sv - per-vector sum of squares with overflow detect and saturation
//
// Purpose: accumulates a*a over VEC_LEN accepted samples and emits one result
// per vector.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, clears all state
//   a         signed sample, IN_W bits
//   valid_in  sample accepted on an edge with valid_in=1 and clr=0
//   clr       synchronous abort of the partial vector (f/overflow kept)
//   f         sum of squares of the last completed vector, ACC_W bits
//   valid_out one-cycle strobe when f/overflow are updated
//   overflow  last completed vector exceeded the ACC_W range
module l2_sumsq_vec
  import l2_pkg::*;
#(
  parameter int IN_W     = IN_W_D,
  parameter int ACC_W    = ACC_W_D,
  parameter int VEC_LEN  = VEC_LEN_D,
  parameter int PIPE     = 1,
  parameter int SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] a,
  input  logic                   valid_in,
  input  logic                   clr,
  output logic [ACC_W-1:0]       f,
  output logic                   valid_out,
  output logic                   overflow
);

  localparam int PROD_W = prod_width(IN_W);
  localparam int CNT_W  = cnt_width(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  logic [PROD_W-1:0] prod;
  logic              prod_valid;

  l2_square_stage #(
    .IN_W (IN_W),
    .PIPE (PIPE)
  ) u_square (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .valid_in   (valid_in),
    .kill       (clr),
    .prod       (prod),
    .prod_valid (prod_valid)
  );

  // Fit the square to the accumulator width; any dropped upper bits count as
  // an overflow of this vector.
  logic [ACC_W-1:0] prod_acc;
  logic             prod_hi;

  if (ACC_W > PROD_W) begin : g_prod_ext
    assign prod_acc = {{(ACC_W - PROD_W){1'b0}}, prod};
    assign prod_hi  = 1'b0;
  end else if (ACC_W == PROD_W) begin : g_prod_eq
    assign prod_acc = prod;
    assign prod_hi  = 1'b0;
  end else begin : g_prod_trunc
    assign prod_acc = prod[ACC_W-1:0];
    assign prod_hi  = |prod[PROD_W-1:ACC_W];
  end

  logic [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;
  logic [ACC_W-1:0] f_d, f_q;
  logic             overflow_d, overflow_q;
  logic             valid_out_d, valid_out_q;

  logic [ACC_W:0]   sum;
  logic             ovf_final;
  logic             acc_event;

  assign sum       = {1'b0, acc_q} + {1'b0, prod_acc};
  assign ovf_final = ovf_q || sum[ACC_W] || prod_hi;
  // An in-flight square arriving on a clr edge is discarded with the vector.
  assign acc_event = prod_valid && !clr;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    f_d         = f_q;
    overflow_d  = overflow_q;
    valid_out_d = 1'b0;

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (acc_event) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        acc_d       = '0;
        ovf_d       = 1'b0;
        f_d         = (ovf_final && (SATURATE != 0)) ? '1 : sum[ACC_W-1:0];
        overflow_d  = ovf_final;
        valid_out_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum[ACC_W-1:0];
        ovf_d = ovf_final;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      f_q         <= '0;
      overflow_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      f_q         <= f_d;
      overflow_q  <= overflow_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign f         = f_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_l2_sumsq_vec.sv
// tb/tb_l2_sumsq_vec.sv - scoreboard bench for l2_sumsq_vec across several configurations
module tb_l2_sumsq_vec;

  localparam int N = 5;
  localparam int C_ACC  [N] = '{20, 16, 16, 20, 12};
  localparam int C_VL   [N] = '{4, 4, 4, 1, 3};
  localparam int C_PIPE [N] = '{1, 1, 1, 0, 0};
  localparam int C_SAT  [N] = '{1, 1, 0, 1, 0};

  typedef struct {
    logic [31:0] f;
    logic        ovf;
    int          edge_n;
  } exp_t;

  typedef struct {
    longint sq;
    int     due;
  } pend_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [7:0] a = '0;
  logic              valid_in = 1'b0;
  logic              clr = 1'b0;

  logic [31:0] f_w   [N];
  logic        vo_w  [N];
  logic        ovf_w [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    logic [C_ACC[gi]-1:0] f_loc;
    logic                 vo_loc;
    logic                 ovf_loc;

    l2_sumsq_vec #(
      .IN_W     (8),
      .ACC_W    (C_ACC[gi]),
      .VEC_LEN  (C_VL[gi]),
      .PIPE     (C_PIPE[gi]),
      .SATURATE (C_SAT[gi])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .valid_in  (valid_in),
      .clr       (clr),
      .f         (f_loc),
      .valid_out (vo_loc),
      .overflow  (ovf_loc)
    );

    assign f_w[gi]   = 32'(f_loc);
    assign vo_w[gi]  = vo_loc;
    assign ovf_w[gi] = ovf_loc;
  end

  always #5 clk = ~clk;

  // Reference model state: samples waiting out the squarer latency, the
  // partial vector, and the expected results.
  pend_t  pend_q [N][$];
  exp_t   exp_q  [N][$];
  longint vec_sum [N];
  int     vec_n   [N];
  int     cyc = 0;
  bit     done = 0;

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      pend_q[i].delete();
      vec_sum[i] = 0;
      vec_n[i]   = 0;
    end
  endtask

  // One clock cycle: drive inputs, then apply the same edge to the model.
  task automatic step(input int av, input bit v, input bit c);
    logic [7:0] a8;
    pend_t      p;
    exp_t       e;
    longint     full;
    longint     mask;
    a8       = av[7:0];
    a        = a8;
    valid_in = v;
    clr      = c;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (c) begin
        pend_q[i].delete();
        vec_sum[i] = 0;
        vec_n[i]   = 0;
      end else begin
        if (v) begin
          p.sq  = longint'(av) * longint'(av);
          p.due = cyc + C_PIPE[i];
          pend_q[i].push_back(p);
        end
        while (pend_q[i].size() > 0 && pend_q[i][0].due <= cyc) begin
          p = pend_q[i].pop_front();
          vec_sum[i] += p.sq;
          vec_n[i]++;
          if (vec_n[i] == C_VL[i]) begin
            full     = longint'(1) << C_ACC[i];
            mask     = full - 1;
            e.ovf    = (vec_sum[i] >= full);
            e.f      = 32'(e.ovf ? ((C_SAT[i] != 0) ? mask : (vec_sum[i] & mask)) : vec_sum[i]);
            e.edge_n = cyc;
            exp_q[i].push_back(e);
            vec_sum[i] = 0;
            vec_n[i]   = 0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1'b0, 1'b0);
  endtask

  task automatic vec4(input int x0, input int x1, input int x2, input int x3);
    step(x0, 1'b1, 1'b0);
    step(x1, 1'b1, 1'b0);
    step(x2, 1'b1, 1'b0);
    step(x3, 1'b1, 1'b0);
  endtask

  // Monitor: compares every strobe against the scoreboard, checks hold
  // behaviour between strobes, and checks the cleared state under reset.
  initial begin : monitor
    exp_t        e;
    logic [31:0] last_f   [N];
    logic        last_ovf [N];
    for (int i = 0; i < N; i++) begin
      last_f[i]   = '0;
      last_ovf[i] = 1'b0;
    end
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #1;
        for (int i = 0; i < N; i++) begin
          last_f[i]   = '0;
          last_ovf[i] = 1'b0;
          checks++;
          if (f_w[i] !== 32'd0 || vo_w[i] !== 1'b0 || ovf_w[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst=%0d got f=%0d valid_out=%b overflow=%b expected 0/0/0",
                     i, f_w[i], vo_w[i], ovf_w[i]);
          end
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (vo_w[i] === 1'b1) begin
            checks++;
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_strobe inst=%0d edge=%0d got f=%0d expected no strobe", i, cyc, f_w[i]);
            end else begin
              e = exp_q[i].pop_front();
              if (f_w[i] !== e.f || ovf_w[i] !== e.ovf || cyc != e.edge_n) begin
                errors++;
                $display("FAIL strobe inst=%0d got f=%0d ovf=%b edge=%0d expected f=%0d ovf=%b edge=%0d",
                         i, f_w[i], ovf_w[i], cyc, e.f, e.ovf, e.edge_n);
              end
              last_f[i]   = e.f;
              last_ovf[i] = e.ovf;
            end
          end else begin
            checks++;
            if (vo_w[i] !== 1'b0 || f_w[i] !== last_f[i] || ovf_w[i] !== last_ovf[i]) begin
              errors++;
              $display("FAIL hold inst=%0d got f=%0d ovf=%b vo=%b expected f=%0d ovf=%b vo=0",
                       i, f_w[i], ovf_w[i], vo_w[i], last_f[i], last_ovf[i]);
            end
            if (exp_q[i].size() > 0 && exp_q[i][0].edge_n <= cyc) begin
              e = exp_q[i].pop_front();
              checks++;
              errors++;
              $display("FAIL missing_strobe inst=%0d at edge=%0d got no strobe expected f=%0d edge=%0d",
                       i, cyc, e.f, e.edge_n);
            end
          end
        end
        if (done) begin
          for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
              errors++;
              $display("FAIL drain inst=%0d got %0d pending results expected 0", i, exp_q[i].size());
            end
          end
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

  initial begin : stimulus
    int av;
    model_clear();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Basic vector, then back-to-back extreme and small vectors.
    vec4(1, 2, 3, 4);
    idle(4);
    vec4(-128, -128, -128, -128);
    vec4(-1, 0, 1, 2);
    idle(3);
    // Overflow vector followed by a clean one; sticky overflow must clear.
    vec4(-128, -128, -128, -128);
    vec4(1, 1, 1, 1);
    idle(3);

    // clr discards the partial vector and the sample presented with it.
    step(5, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    step(9, 1'b1, 1'b1);
    vec4(1, 1, 1, 1);
    idle(3);
    // clr on the edge where the last element is still in the squarer register.
    vec4(7, 7, 7, 7);
    step(0, 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of a vector.
    step(3, 1'b1, 1'b0);
    step(3, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    vec4(2, 2, 2, 2);
    idle(3);

    // Isolated samples with gaps.
    step(7, 1'b1, 1'b0);
    idle(2);
    step(-3, 1'b1, 1'b0);
    idle(3);

    // Randomized traffic with occasional clr and extreme values.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 5))
        0:       av = -128;
        1:       av = 127;
        default: av = int'($urandom_range(0, 255)) - 128;
      endcase
      step(av, ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
    end
    idle(6);
    done = 1;
    idle(2);
    $display("FAIL monitor_timeout got no summary expected summary after drain");
    $fatal(1, "monitor did not finish");
  end

endmodule
